// File: rtl/compute_group_mem_arbiter.sv
// Shared-RAM arbiter for one compute group. It captures one two-address request per
// subleq CPU, issues them to the dual-port RAM one per cycle in round-robin order,
// and hands the read data back to the CPU that owns it.

module compute_group_mem_arbiter_client #(
    parameter int ADDR_W = 17,
    parameter int DATA_W = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              capture,
    input  logic              issue,
    input  logic              complete,
    input  logic [ADDR_W-1:0] req_addr_a,
    input  logic [ADDR_W-1:0] req_addr_b,
    input  logic              req_we_b,
    input  logic [DATA_W-1:0] req_data_b,
    input  logic [DATA_W-1:0] ram_data_a,
    input  logic [DATA_W-1:0] ram_data_b,
    output logic              pend,
    output logic [ADDR_W-1:0] pend_addr_a,
    output logic [ADDR_W-1:0] pend_addr_b,
    output logic              pend_we_b,
    output logic [DATA_W-1:0] pend_data_b,
    output logic [DATA_W-1:0] data_a,
    output logic [DATA_W-1:0] data_b
);

    typedef struct packed {
        logic [ADDR_W-1:0] addr_a;
        logic [ADDR_W-1:0] addr_b;
        logic              we_b;
        logic [DATA_W-1:0] data_b;
    } req_t;

    req_t              req_q;
    logic              pend_q;
    logic [DATA_W-1:0] hold_a;
    logic [DATA_W-1:0] hold_b;

    always_ff @(posedge clock) begin
        if (reset) begin
            req_q  <= '0;
            pend_q <= 1'b0;
            hold_a <= '0;
            hold_b <= '0;
        end else begin
            if (issue)
                pend_q <= 1'b0;
            // a capture and an issue never coincide for the same client
            if (capture) begin
                pend_q <= 1'b1;
                req_q  <= '{addr_a: req_addr_a, addr_b: req_addr_b,
                            we_b: req_we_b, data_b: req_data_b};
            end
            if (complete) begin
                hold_a <= ram_data_a;
                hold_b <= ram_data_b;
            end
        end
    end

    assign pend        = pend_q;
    assign pend_addr_a = req_q.addr_a;
    assign pend_addr_b = req_q.addr_b;
    assign pend_we_b   = req_q.we_b;
    assign pend_data_b = req_q.data_b;

    // RAM data goes straight through in the completion cycle, held copy otherwise
    assign data_a = complete ? ram_data_a : hold_a;
    assign data_b = complete ? ram_data_b : hold_b;

endmodule

module compute_group_mem_arbiter #(
    parameter int ADDR_W = 17,
    parameter int DATA_W = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [ADDR_W-1:0] c0_ram_addr_a,
    input  logic [ADDR_W-1:0] c0_ram_addr_b,
    input  logic              c0_ram_we_b,
    input  logic [DATA_W-1:0] c0_ram_data_b,
    input  logic [ADDR_W-1:0] c1_ram_addr_a,
    input  logic [ADDR_W-1:0] c1_ram_addr_b,
    input  logic              c1_ram_we_b,
    input  logic [DATA_W-1:0] c1_ram_data_b,
    output logic [DATA_W-1:0] ram_c0_data_a,
    output logic [DATA_W-1:0] ram_c0_data_b,
    output logic              ram_c0_en,
    output logic [DATA_W-1:0] ram_c1_data_a,
    output logic [DATA_W-1:0] ram_c1_data_b,
    output logic              ram_c1_en,
    output logic [ADDR_W-1:0] arb_ram_addr_a,
    output logic [ADDR_W-1:0] arb_ram_addr_b,
    output logic              arb_ram_we_b,
    output logic [DATA_W-1:0] arb_ram_data_b,
    input  logic [DATA_W-1:0] ram_arb_data_a,
    input  logic [DATA_W-1:0] ram_arb_data_b
);

    localparam int NUM_CLIENTS = 2;

    logic [NUM_CLIENTS-1:0][ADDR_W-1:0] req_addr_a, req_addr_b;
    logic [NUM_CLIENTS-1:0]             req_we_b;
    logic [NUM_CLIENTS-1:0][DATA_W-1:0] req_data_b;
    logic [NUM_CLIENTS-1:0][ADDR_W-1:0] pend_addr_a, pend_addr_b;
    logic [NUM_CLIENTS-1:0]             pend_we_b;
    logic [NUM_CLIENTS-1:0][DATA_W-1:0] pend_data_b;
    logic [NUM_CLIENTS-1:0][DATA_W-1:0] rsp_data_a, rsp_data_b;
    logic [NUM_CLIENTS-1:0]             pend, infl, complete, en, issue;

    logic kick_done;
    logic kick;
    logic grant_vld;
    logic grant_id;
    logic last_gnt;
    logic win_vld;
    logic win_id;

    assign req_addr_a = {c1_ram_addr_a, c0_ram_addr_a};
    assign req_addr_b = {c1_ram_addr_b, c0_ram_addr_b};
    assign req_we_b   = {c1_ram_we_b,   c0_ram_we_b};
    assign req_data_b = {c1_ram_data_b, c0_ram_data_b};

    // Kick: first cycle out of reset, both CPUs present their first fetch
    assign kick = !reset && !kick_done;

    always_comb begin
        infl = '0;
        for (int i = 0; i < NUM_CLIENTS; i++)
            infl[i] = grant_vld && (grant_id == 1'(i));
    end

    // In-flight data returning while reset is high is dropped
    assign complete = reset ? '0 : infl;
    assign en       = complete | {NUM_CLIENTS{kick}};

    // Round-robin between the two pending clients
    always_comb begin
        win_vld = 1'b0;
        win_id  = 1'b0;
        if (!reset) begin
            if (pend[0] && pend[1]) begin
                win_vld = 1'b1;
                win_id  = ~last_gnt;
            end else if (pend[0]) begin
                win_vld = 1'b1;
                win_id  = 1'b0;
            end else if (pend[1]) begin
                win_vld = 1'b1;
                win_id  = 1'b1;
            end
        end
    end

    assign issue = win_vld ? (NUM_CLIENTS'(1) << win_id) : '0;

    always_comb begin
        arb_ram_addr_a = '0;
        arb_ram_addr_b = '0;
        arb_ram_we_b   = 1'b0;
        arb_ram_data_b = '0;
        if (win_vld) begin
            arb_ram_addr_a = pend_addr_a[win_id];
            arb_ram_addr_b = pend_addr_b[win_id];
            arb_ram_we_b   = pend_we_b[win_id];
            arb_ram_data_b = pend_data_b[win_id];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            kick_done <= 1'b0;
            grant_vld <= 1'b0;
            grant_id  <= 1'b0;
            last_gnt  <= 1'b1;
        end else begin
            kick_done <= 1'b1;
            grant_vld <= win_vld;
            grant_id  <= win_id;
            if (win_vld)
                last_gnt <= win_id;
        end
    end

    for (genvar gi = 0; gi < NUM_CLIENTS; gi++) begin : g_client
        compute_group_mem_arbiter_client #(
            .ADDR_W(ADDR_W),
            .DATA_W(DATA_W)
        ) u_client (
            .clock      (clock),
            .reset      (reset),
            .capture    (en[gi]),
            .issue      (issue[gi]),
            .complete   (complete[gi]),
            .req_addr_a (req_addr_a[gi]),
            .req_addr_b (req_addr_b[gi]),
            .req_we_b   (req_we_b[gi]),
            .req_data_b (req_data_b[gi]),
            .ram_data_a (ram_arb_data_a),
            .ram_data_b (ram_arb_data_b),
            .pend       (pend[gi]),
            .pend_addr_a(pend_addr_a[gi]),
            .pend_addr_b(pend_addr_b[gi]),
            .pend_we_b  (pend_we_b[gi]),
            .pend_data_b(pend_data_b[gi]),
            .data_a     (rsp_data_a[gi]),
            .data_b     (rsp_data_b[gi])
        );
    end

    assign ram_c0_en     = en[0];
    assign ram_c1_en     = en[1];
    assign ram_c0_data_a = rsp_data_a[0];
    assign ram_c0_data_b = rsp_data_b[0];
    assign ram_c1_data_a = rsp_data_a[1];
    assign ram_c1_data_b = rsp_data_b[1];

endmodule

// File: doc/compute_group_mem_arbiter.md
# compute_group_mem_arbiter

Shared-RAM arbiter for the compute group. It sits directly downstream of the two subleq cpu instances (local id 0 and 1) and upstream of the group's dual-port RAM. It captures each CPU's two-address request and issues requests to the RAM one per cycle, alternating between CPUs. It returns read data to the owning CPU and pulses that CPU's ram_c_en in the cycle its data is valid.

## Interface
- ADDR_W, 17, RAM word-address width
- DATA_W, 32, RAM data width
- clock  in  1  single clock, all state on rising edge
- reset  in  1  synchronous, active-high; clears all state
- c0_ram_addr_a / c1_ram_addr_a  in  ADDR_W  CPU port-A read address
- c0_ram_addr_b / c1_ram_addr_b  in  ADDR_W  CPU port-B read/write address
- c0_ram_we_b / c1_ram_we_b  in  1  CPU port-B write enable
- c0_ram_data_b / c1_ram_data_b  in  DATA_W  CPU port-B write data
- ram_c0_data_a / ram_c1_data_a  out  DATA_W  port-A read data to CPU
- ram_c0_data_b / ram_c1_data_b  out  DATA_W  port-B read data to CPU
- ram_c0_en / ram_c1_en  out  1  data valid this cycle; CPU request sampled this cycle
- arb_ram_addr_a, arb_ram_addr_b  out  ADDR_W  RAM addresses
- arb_ram_we_b  out  1  RAM port-B write enable
- arb_ram_data_b  out  DATA_W  RAM port-B write data
- ram_arb_data_a, ram_arb_data_b  in  DATA_W  RAM read data, valid 1 cycle after the address is presented

## Operation
- Per client i: pending request register {addr_a, addr_b, we_b, data_b}, pend_i flag, infl_i flag (issued, data due next cycle). The RAM side has a grant register: valid plus client id.
- Client handshake: in any cycle where ram_ci_en=1, the arbiter captures client i's four request inputs into its pending register at the clock edge and sets pend_i. ram_ci_en is high only in a kick cycle or a completion cycle.
- Kick: in the first cycle with reset low after reset, ram_c0_en = ram_c1_en = 1 and all data outputs are 0. Both requests are captured, so both CPUs present their first fetch.
- Arbitration each cycle: eligible = pend_i. If both are eligible, grant the client not granted last. The last-grant pointer resets to 1, so client 0 wins first. Issue: drive the arb_ram_* outputs from the winner's pending register, set infl_winner, clear pend_winner.
- Completion: a client with infl_i set from the previous cycle gets ram_ci_en=1. ram_ci_data_a/b = ram_arb_data_a/b combinationally, and the new request is captured. A client that completes cannot be issued in the same cycle, because its pend is set only at the edge.
- When no grant is issued: arb_ram_we_b=0, addresses 0, data 0.
- When ram_ci_en=0: ram_ci_data_a/b hold the last delivered value (registered copy).
- Writes: arb_ram_we_b = winner's we_b, written at addr_b. Port-B read data in a write cycle is RAM-defined, and the arbiter forwards it unchanged.
- Reset mid-operation: pending, in-flight, grant and held data are cleared. RAM data returning in the cycle after reset is discarded (no en). The kick repeats after reset drops.

## Timing
- Reset values: all en 0, all data outputs 0, arb_ram_* 0, pend/infl 0, pointer 1.
- Cycle K (first cycle after reset): kick, both en=1.
- K+1: issue c0.
- K+2: complete c0 (en0=1) and issue c1.
- K+3: complete c1 and issue c0, and so on. In steady state the RAM is busy every cycle and each CPU completes every 2 cycles.
- Request-to-data latency: 1 cycle after issue. Capture-to-issue: 1 cycle minimum, 2 if the other client won.
- Single active client (the other has no pend): it issues every second cycle, and the RAM is idle in between.
- At most one en is high per cycle, except in the kick cycle.

## Test plan
- Reset held 3 cycles, then released with CPU models → both en=1 in cycle K; c0 requests addr_a=0/b=1 and c1 requests 4096/4097; arb_ram_addr_a=0 at K+1 and 4096 at K+2.
- RAM preloaded mem[0]=5, mem[1]=7 → at K+2, ram_c0_en=1 with data_a=5 and data_b=7; ram_c1_en=0 and c1 data still 0.
- c0 requests we_b=1, addr_b=20, data_b=0xFFFFFFFE → arb_ram_we_b=1 for exactly one cycle with that addr/data; a later read of addr 20 returns 0xFFFFFFFE.
- Both clients pending for 20 cycles → grants strictly alternate 0,1,0,1…; en0 and en1 are never high together after the kick.
- Client 1 request inputs held constant with no completion (pend cleared) → c0 issues every other cycle, and arb_ram_we_b=0 with addresses 0 in idle cycles.
- reset asserted in an issue cycle → no en in the following cycle, outputs return to reset values, and the kick recurs on the first cycle with reset low.
